// File: rtl/instr_align.sv
// Instruction aligner: queues fetched halfwords and emits one whole 16/32-bit RISC-V instruction per cycle.
// Define INSTR_ALIGN_COMPRESSED_EN for C-extension support; otherwise every item is 32-bit and pc[1]=1 fetches fault.
package instr_align_pkg;
  typedef logic [31:0] program_counter_t;
  typedef logic [3:0]  except_t;

  localparam except_t EXC_NONE         = 4'd0;
  localparam except_t EXC_MISALIGNED   = 4'd1;
  localparam except_t EXC_ACCESS_FAULT = 4'd2;
  localparam except_t EXC_PAGE_FAULT   = 4'd3;

  typedef struct packed {
    logic             valid;
    program_counter_t pc;
    logic [15:0]      data0;
    logic [15:0]      data1;
    except_t          except;
  } fetched_data_t;
endpackage

module instr_align
  import instr_align_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_stall,
  input  fetched_data_t    i_data,
  output logic             o_fetch_stall,
  output logic             o_valid,
  output program_counter_t o_pc,
  output logic [31:0]      o_instr,
  output logic             o_compressed,
  output except_t          o_except
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      hw_q [QUEUE_DEPTH];
  program_counter_t pc_q [QUEUE_DEPTH];
  except_t          ex_q [QUEUE_DEPTH];

  logic [PTR_W-1:0] head, tail, head_nxt1, tail_nxt1;
  logic [CNT_W-1:0] count, free_slots, push_n, pop_n;
  logic             accept, deq, head16, head_ex;

  logic [15:0]      wr_hw0, wr_hw1;
  program_counter_t wr_pc0, wr_pc1;
  except_t          wr_ex0;

  assign head_nxt1 = head + PTR_W'(1);
  assign tail_nxt1 = tail + PTR_W'(1);

  // Backpressure looks only at the registered count, so a same-cycle pop never matters.
  assign free_slots    = CNT_W'(QUEUE_DEPTH) - count;
  assign o_fetch_stall = free_slots < CNT_W'(2);
  assign accept        = i_data.valid & ~o_fetch_stall & ~i_flush;

  always_comb begin
    push_n = '0;
    wr_hw0 = i_data.data0;
    wr_pc0 = i_data.pc;
    wr_ex0 = EXC_NONE;
    wr_hw1 = i_data.data1;
    wr_pc1 = i_data.pc + 32'd2;
    if (accept) begin
      if (i_data.except != EXC_NONE) begin
        push_n = CNT_W'(1);
        wr_hw0 = '0;
        wr_ex0 = i_data.except;
      end else if (i_data.pc[1]) begin
        push_n = CNT_W'(1);
`ifdef INSTR_ALIGN_COMPRESSED_EN
        wr_hw0 = i_data.data1;
`else
        wr_hw0 = '0;
        wr_ex0 = EXC_MISALIGNED;
`endif
      end else begin
        push_n = CNT_W'(2);
      end
    end
  end

`ifdef INSTR_ALIGN_COMPRESSED_EN
  assign head16 = hw_q[head][1:0] != 2'b11;
`else
  assign head16 = 1'b0;
`endif
  assign head_ex = ex_q[head] != EXC_NONE;

  // Head-only items (16-bit or faulting) need one entry; everything else needs the next one too.
  always_comb begin
    o_valid      = 1'b0;
    o_pc         = '0;
    o_instr      = '0;
    o_compressed = 1'b0;
    o_except     = EXC_NONE;
    if ((count >= CNT_W'(1) && (head16 || head_ex)) || count >= CNT_W'(2)) begin
      o_valid = 1'b1;
      o_pc    = pc_q[head];
      if (head_ex) begin
        o_except = ex_q[head];
      end else if (head16) begin
        o_instr      = {16'h0, hw_q[head]};
        o_compressed = 1'b1;
      end else if (ex_q[head_nxt1] != EXC_NONE) begin
        o_except = ex_q[head_nxt1];
      end else begin
        o_instr = {hw_q[head_nxt1], hw_q[head]};
      end
    end
  end

  assign deq   = o_valid & ~i_stall & ~i_flush;
  assign pop_n = !deq ? '0 : (head16 || head_ex) ? CNT_W'(1) : CNT_W'(2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n[PTR_W-1:0];
      tail  <= tail + push_n[PTR_W-1:0];
      count <= count + push_n - pop_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_n != '0) begin
      hw_q[tail] <= wr_hw0;
      pc_q[tail] <= wr_pc0;
      ex_q[tail] <= wr_ex0;
    end
    if (push_n == CNT_W'(2)) begin
      hw_q[tail_nxt1] <= wr_hw1;
      pc_q[tail_nxt1] <= wr_pc1;
      ex_q[tail_nxt1] <= EXC_NONE;
    end
  end

  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count <= CNT_W'(QUEUE_DEPTH));
  a_pop_needs_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (pop_n != '0) |-> o_valid);

endmodule

// File: tb/tb_instr_align.sv
// Bench for instr_align: halfword-queue reference model checked every cycle, plus literal expectations
// for each directed scenario (valid for both settings of INSTR_ALIGN_COMPRESSED_EN).
module tb_instr_align;
  import instr_align_pkg::*;

  localparam int DEPTH = 8;
`ifdef INSTR_ALIGN_COMPRESSED_EN
  localparam bit C = 1'b1;
`else
  localparam bit C = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, stall;
  fetched_data_t    din;
  logic             fetch_stall, valid, compressed;
  program_counter_t pc;
  logic [31:0]      instr;
  except_t          except;

  always #5 clk = ~clk;

  instr_align #(.QUEUE_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_stall      (stall),
    .i_data       (din),
    .o_fetch_stall(fetch_stall),
    .o_valid      (valid),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_compressed (compressed),
    .o_except     (except)
  );

  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
    logic [3:0]  ex;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_live = 1'b0;

  function automatic ent_t mk(input logic [15:0] hw, input logic [31:0] p, input logic [3:0] ex);
    ent_t e;
    e.hw = hw;
    e.pc = p;
    e.ex = ex;
    return e;
  endfunction

  // What the front of the halfword queue must present, and how many halfwords it consumes.
  function automatic void model_out(output logic v, output logic [31:0] p, output logic [31:0] ins,
                                    output logic comp, output logic [3:0] ex, output int pops);
    v = 0; p = 0; ins = 0; comp = 0; ex = 0; pops = 0;
    if (mq.size() == 0) return;
    if (mq[0].ex != 0) begin
      v = 1; p = mq[0].pc; ex = mq[0].ex; pops = 1;
    end else if (C && mq[0].hw[1:0] != 2'b11) begin
      v = 1; p = mq[0].pc; ins = {16'h0, mq[0].hw}; comp = 1; pops = 1;
    end else if (mq.size() >= 2) begin
      v = 1; p = mq[0].pc; pops = 2;
      if (mq[1].ex != 0) ex = mq[1].ex;
      else ins = {mq[1].hw, mq[0].hw};
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_outputs();
    logic v, comp;
    logic [31:0] p, ins;
    logic [3:0] ex;
    int pops;
    if (!model_live) return;
    model_out(v, p, ins, comp, ex, pops);
    chk("valid", 32'(valid), 32'(v));
    chk("pc", pc, p);
    chk("instr", instr, ins);
    chk("compressed", 32'(compressed), 32'(comp));
    chk("except", 32'(except), 32'(ex));
    chk("fetch_stall", 32'(fetch_stall), 32'((DEPTH - mq.size()) < 2));
  endtask

  task automatic model_update();
    logic v, comp, full;
    logic [31:0] p, ins;
    logic [3:0] ex;
    int pops;
    if (!rst_n || flush) begin
      mq.delete();
      model_live = 1'b1;
      return;
    end
    if (!model_live) return;
    model_out(v, p, ins, comp, ex, pops);
    full = (DEPTH - mq.size()) < 2;
    if (v && !stall) repeat (pops) void'(mq.pop_front());
    if (din.valid && !full) begin
      if (din.except != 0) mq.push_back(mk(16'h0, din.pc, din.except));
      else if (din.pc[1]) begin
        if (C) mq.push_back(mk(din.data1, din.pc, 4'h0));
        else   mq.push_back(mk(16'h0, din.pc, EXC_MISALIGNED));
      end else begin
        mq.push_back(mk(din.data0, din.pc, 4'h0));
        mq.push_back(mk(din.data1, din.pc + 32'd2, 4'h0));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [3:0] ex);
    din.valid  = 1'b1;
    din.pc     = p;
    din.data0  = d0;
    din.data1  = d1;
    din.except = ex;
    step();
    din = '0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] p,
                            input logic [31:0] ins, input logic comp, input logic [3:0] ex);
    chk({name, ".valid"}, 32'(valid), 32'(v));
    chk({name, ".pc"}, pc, p);
    chk({name, ".instr"}, instr, ins);
    chk({name, ".comp"}, 32'(compressed), 32'(comp));
    chk({name, ".except"}, 32'(except), 32'(ex));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    din   = '0;
    step();
    step();
    rst_n = 1'b1;
    expect_out("reset", 0, 0, 0, 0, 0);
    chk("reset.fetch_stall", 32'(fetch_stall), 32'd0);

    // Two halfwords of one packet
    send(32'h1000, 16'h4501, 16'h4582, 4'h0);
    expect_out("t1a", 1, 32'h1000, C ? 32'h4501 : 32'h45824501, C, 0);
    step();
    expect_out("t1b", C, C ? 32'h1002 : 32'h0, C ? 32'h4582 : 32'h0, C, 0);
    step();

    // 32-bit then a pair of 16-bit, back to back
    send(32'h2000, 16'h0513, 16'h0010, 4'h0);
    expect_out("t2a", 1, 32'h2000, 32'h00100513, 0, 0);
    send(32'h2004, 16'h0001, 16'h0001, 4'h0);
    expect_out("t2b", 1, 32'h2004, C ? 32'h1 : 32'h00010001, C, 0);
    step();
    expect_out("t2c", C, C ? 32'h2006 : 32'h0, C ? 32'h1 : 32'h0, C, 0);
    step();

    // Straddle across two packets
    send(32'h3000, 16'h4501, 16'h0513, 4'h0);
    expect_out("t3a", 1, 32'h3000, C ? 32'h4501 : 32'h05134501, C, 0);
    step();
    expect_out("t3b", 0, 0, 0, 0, 0);
    send(32'h3004, 16'h0010, 16'h4501, 4'h0);
    expect_out("t3c", 1, C ? 32'h3002 : 32'h3004, C ? 32'h00100513 : 32'h45010010, 0, 0);
    step();
    expect_out("t3d", C, C ? 32'h3006 : 32'h0, C ? 32'h4501 : 32'h0, C, 0);
    step();

    // pc[1]=1: only data1 used (or misaligned fault)
    send(32'h4002, 16'hFFFF, 16'h8082, 4'h0);
    expect_out("t4", 1, 32'h4002, C ? 32'h8082 : 32'h0, C, C ? 4'h0 : EXC_MISALIGNED);
    step();

    // Fill under decode stall
    stall = 1'b1;
    for (int k = 0; k < 4; k++)
      send(32'h6000 + 32'(k * 4), 16'h1001 + 16'(k) * 16'h0200, 16'h1101 + 16'(k) * 16'h0200, 4'h0);
    chk("t5.fetch_stall_full", 32'(fetch_stall), 32'd1);
    expect_out("t5a", 1, 32'h6000, C ? 32'h1001 : 32'h11011001, C, 0);
    send(32'h6010, 16'hAAAA, 16'hBBBB, 4'h0);
    chk("t5.fetch_stall_hold", 32'(fetch_stall), 32'd1);
    expect_out("t5b", 1, 32'h6000, C ? 32'h1001 : 32'h11011001, C, 0);
    stall = 1'b0;
    step();
    expect_out("t5c", 1, C ? 32'h6002 : 32'h6004, C ? 32'h1101 : 32'h13011201, C, 0);
    repeat (9) step();
    expect_out("t5d", 0, 0, 0, 0, 0);

    // Flush with a packet in flight, then a faulting packet
    stall = 1'b1;
    send(32'h7000, 16'h0001, 16'h0001, 4'h0);
    send(32'h7006, 16'h0000, 16'h0002, 4'h0);
    flush = 1'b1;
    din.valid = 1'b1;
    din.pc = 32'h7008;
    din.data0 = 16'h0001;
    din.data1 = 16'h0001;
    din.except = 4'h0;
    step();
    flush = 1'b0;
    stall = 1'b0;
    din = '0;
    expect_out("t6a", 0, 0, 0, 0, 0);
    chk("t6a.fetch_stall", 32'(fetch_stall), 32'd0);
    send(32'h5000, 16'h1234, 16'h5678, EXC_PAGE_FAULT);
    expect_out("t6b", 1, 32'h5000, 0, 0, EXC_PAGE_FAULT);
    step();
    expect_out("t6c", 0, 0, 0, 0, 0);

    // Fault on the upper half of a 32-bit instruction
    send(32'h8002, 16'hFFFF, 16'h0513, 4'h0);
    send(32'h8004, 16'h0000, 16'h0000, EXC_ACCESS_FAULT);
    expect_out("t7", 1, C ? 32'h8002 : 32'h8004, 0, 0, EXC_ACCESS_FAULT);
    repeat (2) step();

    // Mixed back-to-back stream
    for (int i = 0; i < 6; i++) begin
      logic [15:0] lo [6];
      logic [15:0] hi [6];
      lo = '{16'h0001, 16'h0513, 16'h4501, 16'h0010, 16'h0002, 16'h8082};
      hi = '{16'h0513, 16'h0010, 16'h4582, 16'h0097, 16'h0001, 16'h4501};
      send(32'h9000 + 32'(i * 4), lo[i], hi[i], 4'h0);
    end
    repeat (10) step();
    expect_out("t8", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
